// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one word in flight, holds it for the decoder, stalls on control
// transfers until a redirect, and discards a response that a redirect has made stale.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   input  logic        need_inst,
   output logic [31:0] pc,
   output logic [31:0] inst_out,
   output logic        inst_valid,
   input  logic        clear_inst,
   input  logic [31:0] if_addr,
   input  logic        rob_flush,
   input  logic [31:0] rob_flush_addr
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_FETCH      = 3'd1;
   localparam logic [2:0] S_HOLD       = 3'd2;
   localparam logic [2:0] S_WAIT_REDIR = 3'd3;
   localparam logic [2:0] S_DRAIN      = 3'd4;

   logic [2:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        r_inst_vld;

   logic        w_redir;
   logic [31:0] w_redir_pc;
   logic        w_consume;
   logic        w_is_xfer;
   logic        w_in_flight;

   assign w_redir     = rob_flush | clear_inst;
   assign w_redir_pc  = rob_flush ? rob_flush_addr : if_addr;
   assign w_consume   = r_inst_vld & need_inst;
   assign w_in_flight = (r_state == S_FETCH) || (r_state == S_DRAIN);
   // jal, jalr and conditional branches: the next pc comes from a redirect
   assign w_is_xfer   = (r_inst[6:0] == 7'b1101111) ||
                        (r_inst[6:0] == 7'b1100111) ||
                        (r_inst[6:0] == 7'b1100011);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_inst     <= 32'h0;
         r_inst_vld <= 1'b0;
      end else if (rdy) begin
         if (w_redir) begin
            r_pc       <= w_redir_pc;
            r_inst_vld <= 1'b0;
            // a request still in flight must be drained before the new fetch is issued
            r_state    <= (w_in_flight && !mem_ready) ? S_DRAIN : S_FETCH;
         end else begin
            case (r_state)
               S_IDLE: r_state <= S_FETCH;
               S_FETCH: begin
                  if (mem_ready) begin
                     r_inst     <= mem_data;
                     r_inst_vld <= 1'b1;
                     r_state    <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (w_consume) begin
                     r_inst_vld <= 1'b0;
                     if (w_is_xfer) begin
                        r_state <= S_WAIT_REDIR;
                     end else begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_FETCH;
                     end
                  end
               end
               S_WAIT_REDIR: r_state <= S_WAIT_REDIR;
               S_DRAIN: begin
                  if (mem_ready) r_state <= S_FETCH;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign mem_req    = (r_state == S_FETCH);
   assign mem_addr   = r_pc;
   assign pc         = r_pc;
   assign inst_out   = r_inst;
   assign inst_valid = r_inst_vld;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios followed by a randomized run, all checked against a flag-based fetch model.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        mem_req, mem_ready, need_inst, inst_valid;
   logic        clear_inst, rob_flush;
   logic [31:0] mem_addr, mem_data, pc, inst_out, if_addr, rob_flush_addr;

   int n_vec  = 0;
   int n_miss = 0;

   // model: started = left reset idle; pending = word requested from memory;
   // want = that word will be kept (otherwise it is being drained)
   bit          m_started, m_pending, m_want, m_vld;
   logic [31:0] m_pc, m_inst;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
      .need_inst(need_inst), .pc(pc), .inst_out(inst_out), .inst_valid(inst_valid),
      .clear_inst(clear_inst), .if_addr(if_addr),
      .rob_flush(rob_flush), .rob_flush_addr(rob_flush_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_pending = 0; m_want = 0; m_vld = 0;
      m_pc = 32'h0; m_inst = 32'h0;
   endtask

   task automatic model_edge();
      logic [6:0] op;
      if (rdy) begin
         op = m_inst[6:0];
         if (!m_started) begin
            m_started = 1;
            if (rob_flush || clear_inst) m_pc = rob_flush ? rob_flush_addr : if_addr;
            m_pending = 1; m_want = 1;
         end else if (rob_flush || clear_inst) begin
            m_pc  = rob_flush ? rob_flush_addr : if_addr;
            m_vld = 0;
            if (m_pending && !mem_ready) begin
               m_want = 0;
            end else begin
               m_pending = 1; m_want = 1;
            end
         end else if (m_pending) begin
            if (mem_ready) begin
               if (m_want) begin
                  m_inst = mem_data; m_vld = 1; m_pending = 0;
               end else begin
                  m_want = 1;
               end
            end
         end else if (m_vld && need_inst) begin
            m_vld = 0;
            if (!(op == 7'h6f || op == 7'h67 || op == 7'h63)) begin
               m_pc = m_pc + 32'd4;
               m_pending = 1; m_want = 1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".mem_req"},    32'(mem_req),    32'(m_started && m_pending && m_want));
      chk({tag, ".mem_addr"},   mem_addr,        m_pc);
      chk({tag, ".pc"},         pc,              m_pc);
      chk({tag, ".inst_out"},   inst_out,        m_inst);
      chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(m_vld));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      mem_ready = 0; clear_inst = 0; rob_flush = 0;
   endtask

   task automatic pulse_reset();
      rst = 0;
      model_reset();
      #1;
      check_all("rst");
      chk("rst.mem_addr_const", mem_addr, 32'h0);
      chk("rst.mem_req_const", 32'(mem_req), 32'h0);
      rst = 1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 4))
         0: w[6:0] = 7'h6f;
         1: w[6:0] = 7'h67;
         2: w[6:0] = 7'h63;
         3: w[6:0] = 7'h13;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      rst = 0; rdy = 1; mem_ready = 0; mem_data = 0; need_inst = 0;
      clear_inst = 0; if_addr = 0; rob_flush = 0; rob_flush_addr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.inst_valid_const", 32'(inst_valid), 32'h0);
      #1 rst = 1;

      // first fetch after reset, response three cycles into the request
      tick("r37a");
      chk("r37.req", 32'(mem_req), 32'h1);
      chk("r37.addr0", mem_addr, 32'h0);
      tick("r37b");
      tick("r37c");
      mem_ready = 1; mem_data = 32'h0000_0013;
      tick("r37d");
      chk("r37.vld", 32'(inst_valid), 32'h1);
      chk("r37.inst", inst_out, 32'h0000_0013);
      chk("r37.pc", pc, 32'h0);
      need_inst = 1;
      tick("r37e");
      chk("r37.next_addr", mem_addr, 32'h4);
      need_inst = 0;

      // jal stalls until the decoder redirects
      mem_ready = 1; mem_data = 32'h0080_006f;
      tick("r38a");
      need_inst = 1;
      tick("r38b");
      need_inst = 0;
      chk("r38.req_wait", 32'(mem_req), 32'h0);
      tick("r38c");
      tick("r38d");
      chk("r38.still_wait", 32'(mem_req), 32'h0);
      clear_inst = 1; if_addr = 32'h100;
      tick("r38e");
      chk("r38.addr", mem_addr, 32'h100);

      // simultaneous flush and redirect while a request is in flight at pc=8
      mem_ready = 1; mem_data = 32'h0000_0013;
      tick("r39a");
      clear_inst = 1; if_addr = 32'h8;
      tick("r39b");
      chk("r39.at8", mem_addr, 32'h8);
      rob_flush = 1; rob_flush_addr = 32'h40; clear_inst = 1; if_addr = 32'h80;
      tick("r39c");
      chk("r39.drain_req", 32'(mem_req), 32'h0);
      chk("r39.pc", pc, 32'h40);
      tick("r39d");
      mem_ready = 1; mem_data = 32'hdead_beef;
      tick("r39e");
      chk("r39.dropped", 32'(inst_valid), 32'h0);
      chk("r39.addr", mem_addr, 32'h40);

      // decoder stall in HOLD, then redirect
      mem_ready = 1; mem_data = 32'h0000_0013;
      tick("r40a");
      for (int i = 0; i < 5; i++) begin
         tick("r40s");
         chk("r40.vld_stall", 32'(inst_valid), 32'h1);
         chk("r40.inst_stall", inst_out, 32'h0000_0013);
      end
      clear_inst = 1; if_addr = 32'h200;
      tick("r40b");
      chk("r40.vld_after", 32'(inst_valid), 32'h0);
      chk("r40.addr", mem_addr, 32'h200);

      // pc wrap at the top of the address space
      mem_ready = 1; mem_data = 32'h0000_0013;
      tick("r41a");
      clear_inst = 1; if_addr = 32'hffff_fffc;
      tick("r41b");
      mem_ready = 1; mem_data = 32'h0000_0013;
      tick("r41c");
      need_inst = 1;
      tick("r41d");
      need_inst = 0;
      chk("r41.wrap", mem_addr, 32'h0);
      chk("r41.req", 32'(mem_req), 32'h1);

      // freeze during FETCH, response pulse ignored
      rdy = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 1); mem_data = 32'h1234_5013;
         tick("r42f");
         chk("r42.req", 32'(mem_req), 32'h1);
         chk("r42.vld", 32'(inst_valid), 32'h0);
      end
      rdy = 1;
      tick("r42g");
      chk("r42.pending", 32'(mem_req), 32'h1);
      chk("r42.vld_after", 32'(inst_valid), 32'h0);

      // reset mid-request; response at the first edge out of reset is ignored
      #1 pulse_reset();
      mem_ready = 1; mem_data = 32'h0000_0013;
      tick("r35");
      chk("r35.req", 32'(mem_req), 32'h1);
      chk("r35.vld", 32'(inst_valid), 32'h0);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            #1 pulse_reset();
         end
         rdy            = ($urandom_range(0, 9) != 0);
         mem_ready      = ($urandom_range(0, 3) == 0);
         mem_data       = rand_inst();
         need_inst      = ($urandom_range(0, 2) != 0);
         clear_inst     = ($urandom_range(0, 11) == 0);
         rob_flush      = ($urandom_range(0, 15) == 0);
         if_addr        = {$urandom_range(0, 32'hffff), 2'b00} ^ 32'hffff_0000;
         rob_flush_addr = {$urandom_range(0, 32'hffff), 2'b00};
         tick("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
